cnn_frame_sequencer: RTL and testbench

//  Frame-level controller for the conv1 -> pool -> conv2 -> classifier pipeline.

---
 rtl/cnn_seq_pkg.sv | 30 +++
 rtl/cnn_seq_stage_counter.sv | 41 ++++
 rtl/cnn_frame_sequencer.sv | 163 ++++++++++++++++
 tb/tb_cnn_frame_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_seq_pkg.sv
// cnn_seq_pkg: shared definitions for the CNN frame sequencer.
//   - FSM state encoding (IDLE, LAUNCH, RUN, DONE, ERR)
//   - error codes reported on o_err_code
//   - default per-stage beat counts for a 28x28 input frame
package cnn_seq_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_ERR    = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        LAUNCH = ST_LAUNCH,
        RUN    = ST_RUN,
        DONE   = ST_DONE,
        ERR    = ST_ERR
    } seq_state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_OVF      = 2'b10;
    localparam logic [1:0] ERR_MISMATCH = 2'b11;

    localparam int CONV1_OUT_DEF = 576;  // 24x24
    localparam int POOL_OUT_DEF  = 144;  // 12x12
    localparam int CONV2_OUT_DEF = 64;   // 8x8

endpackage

// File: rtl/cnn_seq_stage_counter.sv
// cnn_seq_stage_counter: beat counter for one pipeline stage boundary.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset
//   clr   - clear count (frame launch)
//   en    - counting enabled (frame running)
//   valid - stage output valid
//   full  - count has reached EXP
//   ovf   - valid arriving while already full
// The count saturates at EXP so it never wraps; a beat beyond EXP is
// reported through ovf instead.
module cnn_seq_stage_counter #(
    parameter int EXP   = 576,
    parameter int CNT_W = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic valid,
    output logic full,
    output logic ovf
);

    localparam logic [CNT_W-1:0] EXP_V = CNT_W'(EXP);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] count;

    assign full = (count == EXP_V);
    assign ovf  = valid && full;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && valid && !full) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: frame-level controller for conv1 -> pool -> conv2 ->
// classifier. Accepts one frame request, pulses the fmap feeder, counts
// beats at each stage boundary, runs a watchdog and ends the frame with
// o_done + alpha or a sticky error.
// Ports:
//   clk, reset_n (synchronous, active HIGH despite the name)
//   i_start / o_ready          frame request handshake (ready only in IDLE)
//   o_feed_start               1-cycle launch pulse to the fmap feeder
//   i_conv1/pool/conv2_valid   stage output valids
//   i_result_valid, i_alpha    classifier result
//   o_busy                     frame in flight (LAUNCH or RUN)
//   o_done, o_alpha            frame complete pulse, last good result
//   o_error, o_err_code        sticky error, 01 timeout/10 overflow/11 mismatch
//   i_clear, o_dp_flush        leave ERR, 1-cycle datapath flush pulse
// Optional build macro CNN_SEQ_PERF_EN adds o_frame_cycles: the watchdog
// value captured when a frame completes.
import cnn_seq_pkg::*;

module cnn_frame_sequencer #(
    parameter int CONV1_OUT   = CONV1_OUT_DEF,
    parameter int POOL_OUT    = POOL_OUT_DEF,
    parameter int CONV2_OUT   = CONV2_OUT_DEF,
    parameter int CNT_W       = 10,
    parameter int TIMEOUT_CYC = 8192,
    parameter int TO_W        = 14
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_start,
    output logic            o_ready,
    output logic            o_feed_start,
    input  logic            i_conv1_valid,
    input  logic            i_pool_valid,
    input  logic            i_conv2_valid,
    input  logic            i_result_valid,
    input  logic [7:0]      i_alpha,
    output logic            o_busy,
    output logic            o_done,
    output logic [7:0]      o_alpha,
    output logic            o_error,
    output logic [1:0]      o_err_code,
    input  logic            i_clear,
    output logic            o_dp_flush
`ifdef CNN_SEQ_PERF_EN
    ,
    output logic [TO_W-1:0] o_frame_cycles
`endif
);

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] WD_ONE  = TO_W'(1);

    seq_state_t      state;
    logic [TO_W-1:0] wd;
    logic            run, clr;
    logic            c1_full, c2_full, c3_full;
    logic            c1_ovf, c2_ovf, c3_ovf;
    logic            any_ovf, all_full;

    assign run      = (state == RUN);
    assign clr      = (state == LAUNCH);
    assign any_ovf  = c1_ovf || c2_ovf || c3_ovf;
    assign all_full = c1_full && c2_full && c3_full;

    cnn_seq_stage_counter #(.EXP(CONV1_OUT), .CNT_W(CNT_W)) u_cnt_conv1 (
        .clk(clk), .rst(reset_n), .clr(clr), .en(run),
        .valid(i_conv1_valid), .full(c1_full), .ovf(c1_ovf)
    );
    cnn_seq_stage_counter #(.EXP(POOL_OUT), .CNT_W(CNT_W)) u_cnt_pool (
        .clk(clk), .rst(reset_n), .clr(clr), .en(run),
        .valid(i_pool_valid), .full(c2_full), .ovf(c2_ovf)
    );
    cnn_seq_stage_counter #(.EXP(CONV2_OUT), .CNT_W(CNT_W)) u_cnt_conv2 (
        .clk(clk), .rst(reset_n), .clr(clr), .en(run),
        .valid(i_conv2_valid), .full(c3_full), .ovf(c3_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state        <= IDLE;
            wd           <= '0;
            o_ready      <= 1'b1;
            o_feed_start <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_alpha      <= '0;
            o_error      <= 1'b0;
            o_err_code   <= ERR_NONE;
            o_dp_flush   <= 1'b0;
`ifdef CNN_SEQ_PERF_EN
            o_frame_cycles <= '0;
`endif
        end else begin
            // pulses default low; the transitions below raise them for one cycle
            o_feed_start <= 1'b0;
            o_done       <= 1'b0;
            o_dp_flush   <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start && o_ready) begin
                        state        <= LAUNCH;
                        o_ready      <= 1'b0;
                        o_busy       <= 1'b1;
                        o_feed_start <= 1'b1;
                    end
                end
                LAUNCH: begin
                    wd    <= '0;
                    state <= RUN;
                end
                RUN: begin
                    // overflow beats result beats timeout
                    if (any_ovf) begin
                        state      <= ERR;
                        o_busy     <= 1'b0;
                        o_error    <= 1'b1;
                        o_err_code <= ERR_OVF;
                    end else if (i_result_valid) begin
                        o_busy <= 1'b0;
                        if (all_full) begin
                            state   <= DONE;
                            o_done  <= 1'b1;
                            o_alpha <= i_alpha;
`ifdef CNN_SEQ_PERF_EN
                            o_frame_cycles <= wd;
`endif
                        end else begin
                            state      <= ERR;
                            o_error    <= 1'b1;
                            o_err_code <= ERR_MISMATCH;
                        end
                    end else if (wd == WD_LAST) begin
                        state      <= ERR;
                        o_busy     <= 1'b0;
                        o_error    <= 1'b1;
                        o_err_code <= ERR_TIMEOUT;
                    end else begin
                        wd <= wd + WD_ONE;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                end
                ERR: begin
                    if (i_clear) begin
                        state      <= IDLE;
                        o_ready    <= 1'b1;
                        o_error    <= 1'b0;
                        o_err_code <= ERR_NONE;
                        o_dp_flush <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// tb_cnn_frame_sequencer: directed sequence of frames with randomized beat
// timing, checked against a per-frame count model of the sequencer rules.
module tb_cnn_frame_sequencer;

    localparam int C1 = 576;
    localparam int C2 = 144;
    localparam int C3 = 64;
    localparam int TO = 8192;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       i_start = 1'b0;
    logic       o_ready, o_feed_start;
    logic       i_conv1_valid = 1'b0, i_pool_valid = 1'b0, i_conv2_valid = 1'b0;
    logic       i_result_valid = 1'b0;
    logic [7:0] i_alpha = 8'h00;
    logic       o_busy, o_done, o_error, o_dp_flush;
    logic [7:0] o_alpha;
    logic [1:0] o_err_code;
    logic       i_clear = 1'b0;
`ifdef CNN_SEQ_PERF_EN
    logic [13:0] o_frame_cycles;
`endif

    cnn_frame_sequencer dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .o_ready(o_ready),
        .o_feed_start(o_feed_start), .i_conv1_valid(i_conv1_valid),
        .i_pool_valid(i_pool_valid), .i_conv2_valid(i_conv2_valid),
        .i_result_valid(i_result_valid), .i_alpha(i_alpha), .o_busy(o_busy),
        .o_done(o_done), .o_alpha(o_alpha), .o_error(o_error),
        .o_err_code(o_err_code), .i_clear(i_clear), .o_dp_flush(o_dp_flush)
`ifdef CNN_SEQ_PERF_EN
        , .o_frame_cycles(o_frame_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int run_cyc = 0;           // cycles spent in RUN by the current frame
    int c1 = 0, c2 = 0, c3 = 0; // beats delivered in the current frame
    logic [7:0] exp_alpha = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // advance one clock; outputs are sampled and inputs changed 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        run_cyc++;
    endtask

    task automatic clear_valids();
        i_conv1_valid = 1'b0;
        i_pool_valid  = 1'b0;
        i_conv2_valid = 1'b0;
    endtask

    // request a frame; ends in the first RUN cycle
    task automatic start_frame(input bit hold);
        i_start = 1'b1;
        step();
        chk("launch_feed", o_feed_start, 1);
        chk("launch_ready", o_ready, 0);
        chk("launch_busy", o_busy, 1);
        if (!hold) i_start = 1'b0;
        step();
        chk("feed_one_cycle", o_feed_start, 0);
        run_cyc = 0;
        c1 = 0; c2 = 0; c3 = 0;
    endtask

    // deliver t1/t2/t3 beats with random gaps; ovf reports an overflow ended the frame
    task automatic drive(input int t1, input int t2, input int t3, output bit ovf);
        bit v1, v2, v3;
        ovf = 1'b0;
        while (c1 < t1 || c2 < t2 || c3 < t3) begin
            v1 = (c1 < t1) && ($urandom_range(0, 3) != 0);
            v2 = (c2 < t2) && ($urandom_range(0, 3) != 0);
            v3 = (c3 < t3) && ($urandom_range(0, 3) != 0);
            i_conv1_valid = v1;
            i_pool_valid  = v2;
            i_conv2_valid = v3;
            step();
            if ((v1 && c1 == C1) || (v2 && c2 == C2) || (v3 && c3 == C3)) begin
                ovf = 1'b1;
                clear_valids();
                chk("ovf_error", o_error, 1);
                chk("ovf_code", o_err_code, 2'b10);
                chk("ovf_busy", o_busy, 0);
                return;
            end
            c1 += int'(v1);
            c2 += int'(v2);
            c3 += int'(v3);
            if (o_error !== 1'b0 || o_busy !== 1'b1 || o_feed_start !== 1'b0 || o_ready !== 1'b0) begin
                chk("run_error", o_error, 0);
                chk("run_busy", o_busy, 1);
                chk("run_feed", o_feed_start, 0);
                chk("run_ready", o_ready, 0);
            end
        end
        clear_valids();
    endtask

    task automatic send_result(input logic [7:0] a);
        bit good;
        int exp_cyc;
        good = (c1 == C1) && (c2 == C2) && (c3 == C3);
        exp_cyc = run_cyc;
        i_result_valid = 1'b1;
        i_alpha = a;
        step();
        i_result_valid = 1'b0;
        i_alpha = 8'($urandom);
        if (good) begin
            exp_alpha = a;
            chk("done_pulse", o_done, 1);
            chk("done_alpha", o_alpha, exp_alpha);
            chk("done_error", o_error, 0);
            chk("done_busy", o_busy, 0);
`ifdef CNN_SEQ_PERF_EN
            chk("frame_cycles", o_frame_cycles, exp_cyc);
`endif
            step();
            chk("done_width", o_done, 0);
            chk("idle_ready", o_ready, 1);
        end else begin
            chk("mism_error", o_error, 1);
            chk("mism_code", o_err_code, 2'b11);
            chk("mism_done", o_done, 0);
            chk("mism_alpha", o_alpha, exp_alpha);
        end
        if (exp_cyc < 0) chk("cyc_nonneg", exp_cyc, 0);
    endtask

    task automatic clear_err();
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        chk("flush_pulse", o_dp_flush, 1);
        chk("clear_error", o_error, 0);
        chk("clear_code", o_err_code, 0);
        chk("clear_ready", o_ready, 1);
        step();
        chk("flush_width", o_dp_flush, 0);
    endtask

    initial begin
        bit ovf;
        int k;
        logic [7:0] a;

        // reset state
        step(); step();
        chk("rst_ready", o_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_feed", o_feed_start, 0);
        chk("rst_error", o_error, 0);
        chk("rst_code", o_err_code, 0);
        chk("rst_flush", o_dp_flush, 0);
        chk("rst_alpha", o_alpha, 0);
        reset_n = 1'b0;
        step();
        chk("post_rst_ready", o_ready, 1);

        // valids outside RUN are ignored
        i_conv1_valid = 1'b1; i_pool_valid = 1'b1; i_conv2_valid = 1'b1; i_result_valid = 1'b1;
        step(); step();
        clear_valids(); i_result_valid = 1'b0;
        chk("idle_valid_err", o_error, 0);
        chk("idle_valid_done", o_done, 0);

        // normal frame, alpha 2A
        start_frame(1'b0);
        drive(C1, C2, C3, ovf);
        send_result(8'h2A);

        // start held through a whole frame, then re-accepted after DONE
        start_frame(1'b1);
        drive(C1, C2, C3, ovf);
        a = 8'($urandom);
        i_result_valid = 1'b1; i_alpha = a;
        step();
        i_result_valid = 1'b0;
        exp_alpha = a;
        chk("held_done", o_done, 1);
        chk("held_alpha", o_alpha, exp_alpha);
        chk("held_no_feed", o_feed_start, 0);
        step();
        chk("held_idle_ready", o_ready, 1);
        chk("held_idle_feed", o_feed_start, 0);
        step();
        chk("held_reaccept", o_feed_start, 1);
        i_start = 1'b0;
        step();
        run_cyc = 0; c1 = 0; c2 = 0; c3 = 0;
        drive(C1, C2, C3, ovf);
        send_result(8'($urandom));

        // 577th conv1 beat -> overflow; result afterwards is ignored
        start_frame(1'b0);
        drive(C1 + 1, $urandom_range(0, C2), $urandom_range(0, C3), ovf);
        chk("ovf_seen", ovf, 1);
        i_result_valid = 1'b1; i_alpha = ~exp_alpha; i_start = 1'b1;
        step();
        i_result_valid = 1'b0; i_start = 1'b0;
        chk("err_result_alpha", o_alpha, exp_alpha);
        chk("err_result_done", o_done, 0);
        chk("err_sticky", o_error, 1);
        chk("err_no_accept", o_feed_start, 0);
        clear_err();

        // pooling overflow with other stages random
        start_frame(1'b0);
        drive($urandom_range(0, C1), C2 + 1, $urandom_range(0, C3), ovf);
        chk("ovf2_seen", ovf, 1);
        clear_err();

        // result after only 63 conv2 beats -> mismatch
        start_frame(1'b0);
        drive(C1, C2, C3 - 1, ovf);
        send_result(8'h77);
        clear_err();

        // no result -> timeout after TO cycles in RUN
        start_frame(1'b0);
        k = 0;
        while (o_error !== 1'b1 && k < TO + 100) begin
            step();
            k++;
        end
        chk("timeout_cycles", k, TO);
        chk("timeout_code", o_err_code, 2'b01);
        chk("timeout_alpha", o_alpha, exp_alpha);
        clear_err();

        // result and timeout on the same cycle with full counts -> DONE
        start_frame(1'b0);
        drive(C1, C2, C3, ovf);
        while (run_cyc < TO - 1) step();
        send_result(8'hC3);

        // reset mid-RUN
        start_frame(1'b0);
        drive(100, 20, 5, ovf);
        reset_n = 1'b1;
        step();
        exp_alpha = 8'h00;
        chk("midrst_ready", o_ready, 1);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_alpha", o_alpha, exp_alpha);
        chk("midrst_error", o_error, 0);
        reset_n = 1'b0;
        step();

        // a clean frame after reset still completes
        start_frame(1'b0);
        drive(C1, C2, C3, ovf);
        send_result(8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
